// File: rtl/s_machine_pkg.sv
// s_machine_pkg: state encodings shared by the fetch/execute sequencer and its bench
package s_machine_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        HALT  = 3'd3,
        FAULT = 3'd4
    } state_t;
endpackage

// File: rtl/s_machine_seq_if.sv
// s_machine_seq_if: instruction-memory fetch and execute-unit handshakes
interface s_machine_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_data;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_inst;
    logic              ex_done;
    logic              ex_branch;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_halt;
    modport master (
        output imem_req, imem_addr, ex_valid, ex_inst,
        input  imem_ack, imem_data, ex_done, ex_branch, ex_target, ex_halt
    );
    modport slave (
        input  imem_req, imem_addr, ex_valid, ex_inst,
        output imem_ack, imem_data, ex_done, ex_branch, ex_target, ex_halt
    );
endinterface

// File: rtl/s_machine_wdog.sv
// s_machine_wdog: counts consecutive stalled cycles, trips on the WDOG_CYCLES-th one
module s_machine_wdog #(
    parameter int WDOG_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    output logic trip
);
    localparam int W = $clog2(WDOG_CYCLES + 1);
    logic [W-1:0] cnt_q, cnt_d;
    // a non-stall cycle always coincides with a state change, so it clears the count
    always_comb cnt_d = stall ? cnt_q + 1'b1 : '0;
    assign trip = stall && (cnt_q == W'(WDOG_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/s_machine_seq.sv
// s_machine_seq: fetch/execute sequencer; watchdog fault path enabled by S_MACHINE_WDOG_EN
module s_machine_seq
    import s_machine_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int CNT_W       = 8,
    parameter int WDOG_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    s_machine_seq_if.master     bus,
    output logic [ADDR_W-1:0]   pc,
    output logic [CNT_W-1:0]    count,
    output logic [STATE_W-1:0]  state,
    output logic                halted,
    output logic                fault
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              wdog_trip;

    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 1");
    end

`ifdef S_MACHINE_WDOG_EN
    logic stall;
    assign stall = (state_q == FETCH && !bus.imem_ack) || (state_q == EXEC && !bus.ex_done);
    s_machine_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .trip  (wdog_trip)
    );
    assign fault = state_q == FAULT;
`else
    assign wdog_trip = 1'b0;
    assign fault     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE:  state_d = enable ? FETCH : IDLE;
            FETCH: begin
                if (wdog_trip) state_d = FAULT;
                else if (bus.imem_ack) begin
                    ir_d    = bus.imem_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (wdog_trip) state_d = FAULT;
                else if (bus.ex_done) begin
                    count_d = count_q + 1'b1;
                    pc_d    = bus.ex_branch ? bus.ex_target : pc_q + 1'b1;
                    state_d = bus.ex_halt ? HALT : enable ? FETCH : IDLE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            count_q <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.imem_req  = state_q == FETCH;
    assign bus.imem_addr = pc_q;
    assign bus.ex_valid  = state_q == EXEC;
    assign bus.ex_inst   = ir_q;
    assign pc            = pc_q;
    assign count         = count_q;
    assign state         = state_q;
    assign halted        = state_q == HALT || state_q == FAULT;
endmodule

// File: tb/tb_s_machine_seq.sv
// tb_s_machine_seq: vector table plus hand sequences, fetched words scoreboarded to ex_inst
module tb_s_machine_seq;
    import s_machine_pkg::*;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] pc;
    logic [CW-1:0] count;
    logic [2:0]    state;
    logic          halted;
    logic          fault;

    s_machine_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    s_machine_seq #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .WDOG_CYCLES(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus),
        .pc     (pc),
        .count  (count),
        .state  (state),
        .halted (halted),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    int            n_pass = 0;
    int            n_tot  = 0;
    logic [DW-1:0] sb[$];

    typedef struct {
        logic [DW-1:0] data;
        logic          br;
        logic [AW-1:0] tgt;
        logic [AW-1:0] pc;
        logic [CW-1:0] cnt;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [DW-1:0] d, input logic [AW-1:0] addr, input string tag);
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, " req"}, bus.imem_req, 1);
        chk({tag, " addr"}, bus.imem_addr, addr);
        cyc();
        chk({tag, " req hold"}, {bus.imem_req, bus.imem_addr}, {1'b1, addr});
        bus.imem_ack  = 1'b1;
        bus.imem_data = d;
        sb.push_back(d);
        cyc();
        bus.imem_ack  = 1'b0;
        bus.imem_data = 16'hDEAD;
        chk({tag, " exec latency"}, bus.ex_valid, 1);
    endtask

    task automatic wait_exec(input string tag);
        int n = 0;
        while (!bus.ex_valid && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, " valid"}, bus.ex_valid, 1);
        if (sb.size() == 0) chk({tag, " scoreboard empty"}, 0, 1);
        else chk({tag, " ex_inst"}, bus.ex_inst, sb.pop_front());
    endtask

    task automatic do_exec(input logic br, input logic [AW-1:0] tgt, input logic halt,
                           input logic [AW-1:0] exp_pc, input logic [CW-1:0] exp_cnt,
                           input logic [2:0] exp_st, input string tag);
        logic [DW-1:0] inst;
        wait_exec(tag);
        inst = bus.ex_inst;
        cyc();
        chk({tag, " valid hold"}, {bus.ex_valid, bus.ex_inst}, {1'b1, inst});
        bus.ex_done   = 1'b1;
        bus.ex_branch = br;
        bus.ex_target = tgt;
        bus.ex_halt   = halt;
        cyc();
        bus.ex_done   = 1'b0;
        bus.ex_branch = 1'b0;
        bus.ex_target = 8'h00;
        bus.ex_halt   = 1'b0;
        chk({tag, " pc"}, pc, exp_pc);
        chk({tag, " count"}, count, exp_cnt);
        chk({tag, " state"}, state, exp_st);
    endtask

    initial begin
        logic [AW-1:0] addr;
        vecs[0] = '{data: 16'h1234, br: 1'b0, tgt: 8'h00, pc: 8'h01, cnt: 8'd1};
        vecs[1] = '{data: 16'hBEEF, br: 1'b1, tgt: 8'hFF, pc: 8'hFF, cnt: 8'd2};
        vecs[2] = '{data: 16'h0001, br: 1'b0, tgt: 8'h33, pc: 8'h00, cnt: 8'd3};
        vecs[3] = '{data: 16'h5A5A, br: 1'b1, tgt: 8'h10, pc: 8'h10, cnt: 8'd4};
        vecs[4] = '{data: 16'h00FF, br: 1'b0, tgt: 8'h77, pc: 8'h11, cnt: 8'd5};

        reset = 1'b1;
        enable = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_data = '0;
        bus.ex_done = 1'b0;
        bus.ex_branch = 1'b0;
        bus.ex_target = '0;
        bus.ex_halt = 1'b0;
        cyc();
        cyc();
        chk("reset state", state, 0);
        chk("reset pc", pc, 0);
        chk("reset count", count, 0);
        chk("reset flags", {halted, fault, bus.imem_req, bus.ex_valid}, 0);
        reset = 1'b0;
        cyc();
        chk("idle hold", state, 0);
        enable = 1'b1;
        cyc();
        chk("idle to fetch", state, 1);

        addr = 8'h00;
        for (int i = 0; i < 5; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_fetch(vecs[i].data, addr, tag);
            do_exec(vecs[i].br, vecs[i].tgt, 1'b0, vecs[i].pc, vecs[i].cnt, 3'd1, tag);
            addr = vecs[i].pc;
        end

        do_fetch(16'h7777, 8'h11, "rst");
        wait_exec("rst");
        chk("rst count before", count, 5);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst state", state, 0);
        chk("rst count", count, 0);
        chk("rst ex_valid", bus.ex_valid, 0);
        chk("rst pc", pc, 0);
        sb.delete();

        cyc();
        chk("en fetch", state, 1);
        enable = 1'b0;
        cyc();
        chk("en fetch held", {state, bus.imem_req}, {3'd1, 1'b1});
        do_fetch(16'h4321, 8'h00, "en");
        do_exec(1'b0, 8'h99, 1'b0, 8'h01, 8'd1, 3'd0, "en");
        cyc();
        chk("en stays idle", {state, bus.imem_req}, {3'd0, 1'b0});

        enable = 1'b1;
        cyc();
        do_fetch(16'hABCD, 8'h01, "halt");
        do_exec(1'b1, 8'h40, 1'b1, 8'h40, 8'd2, 3'd3, "halt");
        chk("halt halted", halted, 1);
        bus.imem_ack = 1'b1;
        bus.ex_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("halt hold %0d", i), {state, bus.imem_req, bus.ex_valid}, {3'd3, 2'b00});
        end
        bus.imem_ack = 1'b0;
        bus.ex_done = 1'b0;
        chk("halt pc/count", {pc, count}, {8'h40, 8'd2});

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("wdog fetch", state, 1);
`ifdef S_MACHINE_WDOG_EN
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("wdog stall %0d", i), state, 1);
        end
        cyc();
        chk("wdog fault state", state, 4);
        chk("wdog fault flags", {fault, halted, bus.imem_req}, 3'b110);
        chk("wdog pc/count", {pc, count}, 0);
        cyc();
        chk("wdog fault hold", state, 4);
`else
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk($sformatf("nowdog hold %0d", i), {state, bus.imem_req, fault}, {3'd1, 1'b1, 1'b0});
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
